// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_arb packet multiplexer.
// Imported by the top level, the round-robin arbiter and the assertion checker.
package stream_mux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } fsm_e;

   // Channel-index width; a 1-channel index still needs one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_mux_arb_rr.sv
// Combinational rotate-priority arbiter: grants the first requester at or
// above ptr, wrapping from N-1 back to 0.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = ch_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_vld
);

   // The search is fully unrolled; position k of the rotated search maps to
   // channel (ptr + k) mod N, and the first hit wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the loops can leave it unassigned and infer a latch.
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!gnt_vld && req[i] && (((int'(ptr) + k) % N) == i)) begin
               gnt_vld = 1'b1;
               gnt_idx = W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb_sva.sv
// Concurrent-assertion checker bound into stream_mux_arb: handshake
// exclusivity, stall stability, lock integrity, datapath and producer rules.
module stream_mux_arb_sva
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int CH_W   = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   input logic [NUM_CH-1:0]        in_valid,
   input logic [NUM_CH*DATA_W-1:0] in_data,
   input logic [NUM_CH-1:0]        in_last,
   input logic [NUM_CH-1:0]        in_ready,
   input logic                     out_valid,
   input logic [DATA_W-1:0]        out_data,
   input logic                     out_last,
   input logic [CH_W-1:0]          out_ch,
   input logic                     out_ready,
   input logic                     locked,
   input logic [CH_W-1:0]          lock_ch,
   input logic                     xfer,
   input logic [CH_W-1:0]          gnt_idx,
   input logic [DATA_W-1:0]        gnt_data
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(in_ready));

   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=>
         (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_ch)));

   a_lock_hold: assert property (@(posedge clk) disable iff (!rst_n)
      locked |-> ((in_ready & ~(NUM_CH'(1) << lock_ch)) == '0));

   a_data_path: assert property (@(posedge clk) disable iff (!rst_n)
      xfer |=> (out_valid && (out_data == $past(gnt_data)) && (out_ch == $past(gnt_idx))));

   // Producers may withdraw valid, but while it stays up the beat must not change.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_prod
      a_prod_stable: assert property (@(posedge clk) disable iff (!rst_n)
         (in_valid[i] && !in_ready[i]) |=>
            (!in_valid[i] || ($stable(in_data[i*DATA_W +: DATA_W]) && $stable(in_last[i]))));
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 packet-stream multiplexer with a registered output stage; grant comes
// from sel (MODE=0) or round-robin (MODE=1) and is held for a whole packet.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   parameter  int MODE   = 0,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CH_W-1:0]          sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [CH_W-1:0]          out_ch,
   input  logic                     out_ready,
   output logic                     locked
);

   fsm_e              state, state_nxt;
   logic [CH_W-1:0]   lock_ch;
   logic [CH_W-1:0]   arb_idx;
   logic              arb_vld;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_vld;
   logic              gnt_valid;
   logic              gnt_last;
   logic [DATA_W-1:0] gnt_data;
   logic              can_accept;
   logic              xfer;

   // Candidate grant for a new packet; only consulted while IDLE.
   if (MODE == int'(MODE_RR)) begin : g_rr
      logic [CH_W-1:0] ptr;

      rr_arbiter #(.N(NUM_CH)) u_arb (
         .req     (in_valid),
         .ptr     (ptr),
         .gnt_idx (arb_idx),
         .gnt_vld (arb_vld)
      );

      // Priority advances only once a packet completes, never mid-packet.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ptr <= '0;
         end else if (xfer && gnt_last) begin
            ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
         end
      end
   end else begin : g_sel
      assign arb_idx = sel;
      assign arb_vld = (int'(sel) < NUM_CH);
   end

   always_comb begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
      if (state == LOCK) begin
         gnt_idx = lock_ch;
         gnt_vld = 1'b1;
      end
   end

   assign can_accept = !out_valid || out_ready;

   // Index compare rather than a variable part-select keeps out-of-range
   // select values from ever reaching the channel vectors.
   always_comb begin
      in_ready  = '0;
      gnt_valid = 1'b0;
      gnt_data  = '0;
      gnt_last  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_vld && (gnt_idx == CH_W'(i))) begin
            in_ready[i] = can_accept;
            gnt_valid   = in_valid[i];
            gnt_data    = in_data[i*DATA_W +: DATA_W];
            gnt_last    = in_last[i];
         end
      end
   end

   assign xfer = gnt_valid && can_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      locked    = (state == LOCK);
      case (state)
         IDLE:    if (xfer && !gnt_last) state_nxt = LOCK;
         LOCK:    if (xfer &&  gnt_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_ch <= '0;
      end else if ((state == IDLE) && xfer) begin
         lock_ch <= gnt_idx;
      end
   end

   // Output register: load on any transfer (also replaces a beat being
   // consumed this cycle), drop valid only when the sink takes the beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_last  <= gnt_last;
         out_ch    <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   stream_mux_arb_sva #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_sva (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ch    (out_ch),
      .out_ready (out_ready),
      .locked    (locked),
      .lock_ch   (lock_ch),
      .xfer      (xfer),
      .gnt_idx   (gnt_idx),
      .gnt_data  (gnt_data)
   );

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a 4-channel SEL instance, a 4-channel RR
// instance and a 3-channel SEL instance for the out-of-range select case.
module tb_stream_mux_arb;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 4-channel MODE=0 instance
   logic [1:0]  s_sel;
   logic [3:0]  s_valid, s_last, s_ready;
   logic [31:0] s_data;
   logic        s_ovalid, s_olast, s_ordy, s_locked;
   logic [7:0]  s_odata;
   logic [1:0]  s_och;

   // 4-channel MODE=1 instance
   logic [1:0]  r_sel;
   logic [3:0]  r_valid, r_last, r_ready;
   logic [31:0] r_data;
   logic        r_ovalid, r_olast, r_ordy, r_locked;
   logic [7:0]  r_odata;
   logic [1:0]  r_och;

   // 3-channel MODE=0 instance (sel can express an out-of-range channel)
   logic [1:0]  t_sel;
   logic [2:0]  t_valid, t_last, t_ready;
   logic [23:0] t_data;
   logic        t_ovalid, t_olast, t_ordy, t_locked;
   logic [7:0]  t_odata;
   logic [1:0]  t_och;

   int n_assert = 0;
   int n_fail   = 0;

   stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u_sel (
      .clk(clk), .rst_n(rst_n), .sel(s_sel), .in_valid(s_valid), .in_data(s_data),
      .in_last(s_last), .in_ready(s_ready), .out_valid(s_ovalid), .out_data(s_odata),
      .out_last(s_olast), .out_ch(s_och), .out_ready(s_ordy), .locked(s_locked));

   stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .sel(r_sel), .in_valid(r_valid), .in_data(r_data),
      .in_last(r_last), .in_ready(r_ready), .out_valid(r_ovalid), .out_data(r_odata),
      .out_last(r_olast), .out_ch(r_och), .out_ready(r_ordy), .locked(r_locked));

   stream_mux_arb #(.NUM_CH(3), .DATA_W(8), .MODE(0)) u_sel3 (
      .clk(clk), .rst_n(rst_n), .sel(t_sel), .in_valid(t_valid), .in_data(t_data),
      .in_last(t_last), .in_ready(t_ready), .out_valid(t_ovalid), .out_data(t_odata),
      .out_last(t_olast), .out_ch(t_och), .out_ready(t_ordy), .locked(t_locked));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      s_sel  = '0; s_valid = '0; s_last = '0; s_data = '0; s_ordy = 1'b1;
      r_sel  = '0; r_valid = '0; r_last = '0; r_data = '0; r_ordy = 1'b1;
      t_sel  = '0; t_valid = '0; t_last = '0; t_data = '0; t_ordy = 1'b1;

      #12;
      check("rst_out_valid", 32'(r_ovalid), 32'd0);
      check("rst_out_data",  32'(r_odata),  32'd0);
      check("rst_out_last",  32'(r_olast),  32'd0);
      check("rst_out_ch",    32'(r_och),    32'd0);
      check("rst_locked",    32'(r_locked), 32'd0);
      check("rst_sel_valid", 32'(s_ovalid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // ---- Reset mid-packet (RR). Single beat on ch1 moves ptr to 2 first.
      r_valid = 4'b0010; r_last = 4'b0010; r_data[15:8] = 8'h11;
      settle();
      check("t1_ready_ch1", 32'(r_ready), 32'b0010);
      tick();
      check("t1_single_data", 32'(r_odata),  32'h11);
      check("t1_single_ch",   32'(r_och),    32'd1);
      check("t1_single_lock", 32'(r_locked), 32'd0);
      r_valid = 4'b0100; r_last = 4'b0000; r_data[23:16] = 8'h21;
      settle();
      check("t1_ready_ch2", 32'(r_ready), 32'b0100);
      tick();
      check("t1_b1_data", 32'(r_odata),  32'h21);
      check("t1_b1_lock", 32'(r_locked), 32'd1);
      r_data[23:16] = 8'h22;
      tick();
      check("t1_b2_data", 32'(r_odata), 32'h22);
      r_data[23:16] = 8'h23;
      rst_n = 1'b0;
      settle();
      check("t1_async_valid", 32'(r_ovalid), 32'd0);
      check("t1_async_lock",  32'(r_locked), 32'd0);
      r_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();
      // ch0 and ch3 both request: a reset pointer picks ch0, a kept one picks ch3.
      r_valid = 4'b1001; r_last = 4'b1001; r_data[7:0] = 8'h05; r_data[31:24] = 8'h35;
      settle();
      check("t1_post_ready", 32'(r_ready), 32'b0001);
      tick();
      check("t1_post_ch",   32'(r_och),   32'd0);
      check("t1_post_data", 32'(r_odata), 32'h05);
      r_valid = 4'b1000;
      tick();
      check("t1_next_ch",   32'(r_och),   32'd3);
      check("t1_next_data", 32'(r_odata), 32'h35);
      r_valid = '0;
      tick();
      check("t1_drain", 32'(r_ovalid), 32'd0);

      // ---- Round-robin over four continuous single-beat requesters (ptr = 0).
      r_valid = 4'b1111; r_last = 4'b1111; r_data = 32'hC3C2C1C0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_valid", 32'(r_ovalid), 32'd1);
         check("t3_ch",    32'(r_och),    32'(k % 4));
         check("t3_data",  32'(r_odata),  32'(8'hC0 + (k % 4)));
      end
      r_valid = '0; r_last = '0;
      tick();
      check("t3_drain", 32'(r_ovalid), 32'd0);

      // ---- No preemption: ch2 5-beat packet against ch0/ch3 (ptr = 1).
      r_valid = 4'b1101; r_last = 4'b1001;
      r_data  = {8'h3A, 8'h51, 8'h00, 8'h0A};
      settle();
      check("t5_ready_start", 32'(r_ready), 32'b0100);
      tick();
      check("t5_b1_data", 32'(r_odata),  32'h51);
      check("t5_b1_lock", 32'(r_locked), 32'd1);
      for (int b = 2; b <= 4; b++) begin
         r_data[23:16] = 8'(8'h50 + b);
         settle();
         check("t5_ready_lock", 32'(r_ready), 32'b0100);
         tick();
         check("t5_data", 32'(r_odata), 32'(8'h50 + b));
         check("t5_ch",   32'(r_och),   32'd2);
      end
      r_data[23:16] = 8'h55; r_last[2] = 1'b1;
      tick();
      check("t5_last_data", 32'(r_odata),  32'h55);
      check("t5_last_flag", 32'(r_olast),  32'd1);
      check("t5_unlock",    32'(r_locked), 32'd0);
      r_valid = 4'b1001;
      settle();
      check("t5_ready_ch3", 32'(r_ready), 32'b1000);
      tick();
      check("t5_ch3", 32'(r_och),   32'd3);
      check("t5_d3",  32'(r_odata), 32'h3A);
      r_valid = 4'b0001;
      tick();
      check("t5_ch0", 32'(r_och),   32'd0);
      check("t5_d0",  32'(r_odata), 32'h0A);
      r_valid = '0;
      tick();
      check("t5_drain", 32'(r_ovalid), 32'd0);

      // ---- SEL mode: sel changes during a locked packet are ignored.
      s_sel = 2'd1; s_valid = 4'b1010; s_last = 4'b1000;
      s_data = {8'hD3, 8'h00, 8'hA1, 8'h00};
      settle();
      check("t2_ready_ch1", 32'(s_ready), 32'b0010);
      tick();
      check("t2_b1_data", 32'(s_odata),  32'hA1);
      check("t2_b1_ch",   32'(s_och),    32'd1);
      check("t2_b1_lock", 32'(s_locked), 32'd1);
      s_sel = 2'd3; s_data[15:8] = 8'hA2;
      settle();
      check("t2_ready_held", 32'(s_ready), 32'b0010);
      tick();
      check("t2_b2_data", 32'(s_odata), 32'hA2);
      check("t2_b2_ch",   32'(s_och),   32'd1);
      s_data[15:8] = 8'hA3; s_last[1] = 1'b1;
      tick();
      check("t2_b3_data", 32'(s_odata),  32'hA3);
      check("t2_b3_last", 32'(s_olast),  32'd1);
      check("t2_unlock",  32'(s_locked), 32'd0);
      s_valid = 4'b1000;
      settle();
      check("t2_ready_ch3", 32'(s_ready), 32'b1000);
      tick();
      check("t2_ch3",   32'(s_och),   32'd3);
      check("t2_d3",    32'(s_odata), 32'hD3);
      s_valid = '0; s_last = '0;
      tick();
      check("t2_drain", 32'(s_ovalid), 32'd0);

      // ---- Backpressure: three stalled cycles in the middle of a 4-beat packet.
      s_sel = 2'd0; s_valid = 4'b0001; s_data[7:0] = 8'h41;
      tick();
      check("t4_b1", 32'(s_odata), 32'h41);
      s_data[7:0] = 8'h42;
      tick();
      check("t4_b2", 32'(s_odata), 32'h42);
      s_ordy = 1'b0; s_data[7:0] = 8'h43;
      settle();
      check("t4_ready_stall", 32'(s_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t4_hold_valid", 32'(s_ovalid), 32'd1);
         check("t4_hold_data",  32'(s_odata),  32'h42);
         check("t4_hold_ch",    32'(s_och),    32'd0);
         check("t4_hold_last",  32'(s_olast),  32'd0);
         check("t4_hold_ready", 32'(s_ready),  32'd0);
      end
      s_ordy = 1'b1;
      settle();
      check("t4_ready_resume", 32'(s_ready), 32'b0001);
      tick();
      check("t4_b3", 32'(s_odata), 32'h43);
      s_data[7:0] = 8'h44; s_last = 4'b0001;
      tick();
      check("t4_b4",      32'(s_odata),  32'h44);
      check("t4_b4_last", 32'(s_olast),  32'd1);
      check("t4_unlock",  32'(s_locked), 32'd0);
      s_valid = '0; s_last = '0;
      tick();
      check("t4_drain", 32'(s_ovalid), 32'd0);

      // ---- Selected channel idle: other valid channels must not transfer.
      s_sel = 2'd2; s_valid = 4'b1011; s_last = 4'b1111;
      settle();
      check("sel_idle_ready", 32'(s_ready), 32'b0100);
      tick();
      check("sel_idle_valid", 32'(s_ovalid), 32'd0);
      s_valid = '0;

      // ---- Out-of-range select on the 3-channel instance.
      t_sel = 2'd3; t_valid = 3'b111; t_last = 3'b111; t_data = 24'h636261;
      settle();
      check("t6_ready_none", 32'(t_ready), 32'd0);
      for (int c = 0; c < 2; c++) begin
         tick();
         check("t6_no_valid", 32'(t_ovalid), 32'd0);
      end
      t_sel = 2'd2;
      settle();
      check("t6_ready_ch2", 32'(t_ready), 32'b100);
      tick();
      check("t6_ch2",   32'(t_och),   32'd2);
      check("t6_d2",    32'(t_odata), 32'h63);
      t_valid = '0;
      tick();
      check("t6_drain", 32'(t_ovalid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
